// File: rtl/i2c_req_arbiter.sv
// rtl/i2c_req_arbiter.sv - round-robin arbiter sharing one I2C register engine between N_REQ requesters
//
// Purpose: latches one single-byte transaction per requester, grants the engine
// round-robin, issues a one-cycle start pulse, waits for i2c_rw_done and returns
// a one-cycle completion pulse (plus read data) to the owner.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   req_wr, req_rd    [N_REQ]       per-requester write/read request pulses
//   req_id            [8*N_REQ]     slave id per requester
//   req_addr_mode     [N_REQ]       1 = 16-bit register address
//   req_addr          [16*N_REQ]    register address per requester
//   req_wrdata        [8*N_REQ]     write byte per requester
//   req_busy          [N_REQ]       slot pending or transaction in flight
//   req_done, req_err [N_REQ]       completion / timeout pulses to the owner
//   req_rddata        [8]           data of the last completed read
//   id, addr_mode, addr, i2c_wrdata engine target fields (held until next grant)
//   i2c_wrreg_req, i2c_rdreg_req    engine start pulses
//   i2c_rddata, i2c_rw_done         engine read byte / completion
//
// Optional feature: define I2C_ARB_TIMEOUT_EN to add a WAIT watchdog of
// TIMEOUT_CYCLES cycles that completes the transaction with req_err.

module i2c_req_arbiter #(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_wr,
    input  logic [N_REQ-1:0]      req_rd,
    input  logic [8*N_REQ-1:0]    req_id,
    input  logic [N_REQ-1:0]      req_addr_mode,
    input  logic [16*N_REQ-1:0]   req_addr,
    input  logic [8*N_REQ-1:0]    req_wrdata,
    output logic [N_REQ-1:0]      req_busy,
    output logic [N_REQ-1:0]      req_done,
    output logic [N_REQ-1:0]      req_err,
    output logic [7:0]            req_rddata,
    output logic [7:0]            id,
    output logic                  addr_mode,
    output logic [15:0]           addr,
    output logic                  i2c_wrreg_req,
    output logic                  i2c_rdreg_req,
    output logic [7:0]            i2c_wrdata,
    input  logic [7:0]            i2c_rddata,
    input  logic                  i2c_rw_done
);

    localparam int PW = $clog2(N_REQ);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t state, state_next;

    logic [N_REQ-1:0]        pending;
    logic [N_REQ-1:0]        slot_rw;
    logic [N_REQ-1:0][7:0]   slot_id;
    logic [N_REQ-1:0]        slot_mode;
    logic [N_REQ-1:0][15:0]  slot_addr;
    logic [N_REQ-1:0][7:0]   slot_wrdata;

    logic [PW-1:0]           rr_ptr;
    logic [PW-1:0]           owner;
    logic                    owner_rw;
    logic [PW-1:0]           winner;
    logic                    found;
    int                      idx;
    logic [N_REQ-1:0]        load_ok;
    logic                    timeout_hit;

    // First pending slot at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && pending[idx]) begin
                found  = 1'b1;
                winner = PW'(idx);
            end
        end
    end

    // The owner may repost in the cycle its req_done is visible, even though
    // req_busy is still high in that cycle.
    for (genvar g = 0; g < N_REQ; g++) begin : g_busy
        assign req_busy[g] = pending[g] | ((owner == PW'(g)) && (state != S_IDLE));
        assign load_ok[g]  = !req_busy[g] || req_done[g];
    end

    // Per-requester slots; a simultaneous wr+rd pulse keeps the write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending     <= '0;
            slot_rw     <= '0;
            slot_id     <= '0;
            slot_mode   <= '0;
            slot_addr   <= '0;
            slot_wrdata <= '0;
        end else begin
            if (state == S_ISSUE) pending[owner] <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                if (load_ok[i] && (req_wr[i] || req_rd[i])) begin
                    pending[i]     <= 1'b1;
                    slot_rw[i]     <= req_wr[i];
                    slot_id[i]     <= req_id[8*i +: 8];
                    slot_mode[i]   <= req_addr_mode[i];
                    slot_addr[i]   <= req_addr[16*i +: 16];
                    slot_wrdata[i] <= req_wrdata[8*i +: 8];
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // FSM next state
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (found) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (i2c_rw_done || timeout_hit) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        i2c_wrreg_req = 1'b0;
        i2c_rdreg_req = 1'b0;
        req_done      = '0;
        if (state == S_ISSUE) begin
            i2c_wrreg_req = owner_rw;
            i2c_rdreg_req = !owner_rw;
        end
        if (state == S_DONE) req_done[owner] = 1'b1;
    end

    // Grant bookkeeping, engine fields and returned read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr     <= '0;
            owner      <= '0;
            owner_rw   <= 1'b0;
            id         <= '0;
            addr_mode  <= 1'b0;
            addr       <= '0;
            i2c_wrdata <= '0;
            req_rddata <= '0;
        end else begin
            if (state == S_IDLE && found) begin
                owner      <= winner;
                owner_rw   <= slot_rw[winner];
                id         <= slot_id[winner];
                addr_mode  <= slot_mode[winner];
                addr       <= slot_addr[winner];
                i2c_wrdata <= slot_wrdata[winner];
            end
            if (state == S_WAIT) begin
                if (i2c_rw_done) begin
                    if (!owner_rw) req_rddata <= i2c_rddata;
                end else if (timeout_hit) begin
                    req_rddata <= 8'h00;
                end
            end
            if (state == S_DONE) begin
                rr_ptr <= (owner == PW'(N_REQ-1)) ? '0 : owner + 1'b1;
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        err_flag;

    // Counter restarts on every entry to WAIT (the preceding state is ISSUE).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt   <= '0;
            err_flag <= 1'b0;
        end else begin
            if (state == S_ISSUE)     wd_cnt <= '0;
            else if (state == S_WAIT) wd_cnt <= wd_cnt + 32'd1;
            if (state == S_IDLE && found) err_flag <= 1'b0;
            else if (timeout_hit)         err_flag <= 1'b1;
        end
    end

    assign timeout_hit = (state == S_WAIT) && !i2c_rw_done &&
                         (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign req_err     = {N_REQ{err_flag}} & req_done;
`else
    assign timeout_hit = 1'b0;
    assign req_err     = '0;
`endif

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb/tb_i2c_req_arbiter.sv - self-checking bench for i2c_req_arbiter
module tb_i2c_req_arbiter;

    localparam int N = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_wr, req_rd, req_addr_mode;
    logic [8*N-1:0]  req_id, req_wrdata;
    logic [16*N-1:0] req_addr;
    logic [N-1:0]  req_busy, req_done, req_err;
    logic [7:0]    req_rddata, id, i2c_wrdata, i2c_rddata;
    logic          addr_mode, i2c_wrreg_req, i2c_rdreg_req, i2c_rw_done;
    logic [15:0]   addr;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        rw;
        logic [7:0]  id;
        logic        mode;
        logic [15:0] addr;
        logic [7:0]  wd;
    } grant_t;

    typedef struct packed {
        logic [N-1:0] done;
        logic [N-1:0] err;
        logic         chk;
        logic [7:0]   rd;
    } done_t;

    grant_t grant_q[$];
    done_t  done_q[$];
    grant_t mg;
    done_t  md;
    logic   prev_start = 1'b0;

    i2c_req_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset),
        .req_wr(req_wr), .req_rd(req_rd), .req_id(req_id),
        .req_addr_mode(req_addr_mode), .req_addr(req_addr), .req_wrdata(req_wrdata),
        .req_busy(req_busy), .req_done(req_done), .req_err(req_err), .req_rddata(req_rddata),
        .id(id), .addr_mode(addr_mode), .addr(addr),
        .i2c_wrreg_req(i2c_wrreg_req), .i2c_rdreg_req(i2c_rdreg_req),
        .i2c_wrdata(i2c_wrdata), .i2c_rddata(i2c_rddata), .i2c_rw_done(i2c_rw_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "global timeout");
    end

    // Scoreboard monitor: pops expected grants and completions as they appear.
    always @(negedge clk) begin
        if (reset) begin
            prev_start = 1'b0;
        end else begin
            if (prev_start) begin
                checks++;
                if (i2c_wrreg_req || i2c_rdreg_req) begin
                    errors++;
                    $display("FAIL start_width: start pulse high for 2 cycles, required 1");
                end
            end
            if (i2c_wrreg_req || i2c_rdreg_req) begin
                checks++;
                if (grant_q.size() == 0) begin
                    errors++;
                    $display("FAIL grant_unexpected: id=%h addr=%h, required no grant", id, addr);
                end else begin
                    mg = grant_q.pop_front();
                    if ({i2c_wrreg_req, i2c_rdreg_req, id, addr_mode, addr, i2c_wrdata} !==
                        {mg.rw, !mg.rw, mg.id, mg.mode, mg.addr, mg.wd}) begin
                        errors++;
                        $display("FAIL grant_fields: got wr=%b rd=%b id=%h m=%b a=%h d=%h required wr=%b id=%h m=%b a=%h d=%h",
                                 i2c_wrreg_req, i2c_rdreg_req, id, addr_mode, addr, i2c_wrdata,
                                 mg.rw, mg.id, mg.mode, mg.addr, mg.wd);
                    end
                end
            end
            if (|req_done) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: req_done=%b, required none", req_done);
                end else begin
                    md = done_q.pop_front();
                    if ({req_done, req_err} !== {md.done, md.err} ||
                        (md.chk && req_rddata !== md.rd)) begin
                        errors++;
                        $display("FAIL done_fields: got done=%b err=%b rddata=%h required done=%b err=%b rddata=%h",
                                 req_done, req_err, req_rddata, md.done, md.err, md.rd);
                    end
                end
            end
            prev_start = i2c_wrreg_req || i2c_rdreg_req;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int r, input logic wr, input logic rd, input logic [7:0] idv,
                             input logic mode, input logic [15:0] a, input logic [7:0] d);
        req_wr[r]            = wr;
        req_rd[r]            = rd;
        req_id[8*r +: 8]     = idv;
        req_addr_mode[r]     = mode;
        req_addr[16*r +: 16] = a;
        req_wrdata[8*r +: 8] = d;
    endtask

    task automatic release_req;
        req_wr = '0;
        req_rd = '0;
    endtask

    task automatic push_grant(input logic rw, input logic [7:0] idv, input logic mode,
                              input logic [15:0] a, input logic [7:0] d);
        grant_t g;
        g.rw = rw; g.id = idv; g.mode = mode; g.addr = a; g.wd = d;
        grant_q.push_back(g);
    endtask

    task automatic push_done(input logic [N-1:0] dn, input logic [N-1:0] er,
                             input logic chk, input logic [7:0] rd);
        done_t e;
        e.done = dn; e.err = er; e.chk = chk; e.rd = rd;
        done_q.push_back(e);
    endtask

    // Engine model: waits for a start pulse, spends two WAIT cycles, completes.
    // Returns in the cycle after i2c_rw_done (the DONE cycle).
    task automatic serve(input logic [7:0] rd);
        int n = 0;
        while (!(i2c_wrreg_req || i2c_rdreg_req) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL serve_no_start: no start pulse within 50 cycles");
        end else begin
            tick();
            tick();
            i2c_rddata  = rd;
            i2c_rw_done = 1'b1;
            tick();
            i2c_rw_done = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        release_req();
        req_id = '0; req_addr_mode = '0; req_addr = '0; req_wrdata = '0;
        i2c_rddata = '0; i2c_rw_done = 1'b0;
        repeat (3) tick();
        checks++;
        if ({req_busy, req_done, req_err, req_rddata} !== '0) begin
            errors++;
            $display("FAIL reset_req_outputs: busy=%b done=%b err=%b rddata=%h required 0",
                     req_busy, req_done, req_err, req_rddata);
        end
        checks++;
        if ({id, addr_mode, addr, i2c_wrreg_req, i2c_rdreg_req, i2c_wrdata} !== '0) begin
            errors++;
            $display("FAIL reset_engine_outputs: id=%h m=%b a=%h wr=%b rd=%b d=%h required 0",
                     id, addr_mode, addr, i2c_wrreg_req, i2c_rdreg_req, i2c_wrdata);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_write;
        drive_req(0, 1'b1, 1'b0, 8'hA0, 1'b1, 16'h1234, 8'h5A);
        push_grant(1'b1, 8'hA0, 1'b1, 16'h1234, 8'h5A);
        push_done(2'b01, 2'b00, 1'b0, 8'h00);
        tick();                                   // cycle 1
        release_req();
        checks++;
        if (req_busy !== 2'b01 || i2c_wrreg_req !== 1'b0) begin
            errors++;
            $display("FAIL sw_cycle1: busy=%b wrreg=%b required busy=01 wrreg=0", req_busy, i2c_wrreg_req);
        end
        tick();                                   // cycle 2: ISSUE
        checks++;
        if (i2c_wrreg_req !== 1'b1 || i2c_rdreg_req !== 1'b0) begin
            errors++;
            $display("FAIL sw_issue_cycle2: wrreg=%b rdreg=%b required 1 0", i2c_wrreg_req, i2c_rdreg_req);
        end
        tick();                                   // cycle 3: WAIT
        tick();
        tick();                                   // cycle 5
        i2c_rddata  = 8'h77;
        i2c_rw_done = 1'b1;
        tick();                                   // cycle 6: DONE
        i2c_rw_done = 1'b0;
        checks++;
        if (req_done !== 2'b01 || req_rddata !== 8'h00) begin
            errors++;
            $display("FAIL sw_done: done=%b rddata=%h required 01 00", req_done, req_rddata);
        end
        tick();                                   // cycle 7: IDLE
        checks++;
        if (req_done !== 2'b00 || req_busy !== 2'b00) begin
            errors++;
            $display("FAIL sw_after_done: done=%b busy=%b required 00 00", req_done, req_busy);
        end
    endtask

    task automatic test_read_return;
        drive_req(1, 1'b0, 1'b1, 8'h50, 1'b0, 16'h0042, 8'h00);
        push_grant(1'b0, 8'h50, 1'b0, 16'h0042, 8'h00);
        push_done(2'b10, 2'b00, 1'b1, 8'hC3);
        tick();
        release_req();
        serve(8'hC3);                             // DONE cycle
        checks++;
        if (req_done !== 2'b10 || req_rddata !== 8'hC3) begin
            errors++;
            $display("FAIL rd_return: done=%b rddata=%h required 10 c3", req_done, req_rddata);
        end
        // Repost in the same cycle req_done is seen.
        drive_req(1, 1'b1, 1'b0, 8'h51, 1'b1, 16'hBEEF, 8'h3C);
        push_grant(1'b1, 8'h51, 1'b1, 16'hBEEF, 8'h3C);
        push_done(2'b10, 2'b00, 1'b1, 8'hC3);
        tick();                                   // k+2: IDLE with pending
        release_req();
        checks++;
        if (i2c_wrreg_req !== 1'b0 || req_busy !== 2'b10) begin
            errors++;
            $display("FAIL reload_k2: wrreg=%b busy=%b required 0 10", i2c_wrreg_req, req_busy);
        end
        tick();                                   // k+3: ISSUE
        checks++;
        if (i2c_wrreg_req !== 1'b1) begin
            errors++;
            $display("FAIL reload_issue_k3: wrreg=%b required 1", i2c_wrreg_req);
        end
        serve(8'h11);
        checks++;
        if (req_rddata !== 8'hC3) begin
            errors++;
            $display("FAIL rd_held_after_write: rddata=%h required c3", req_rddata);
        end
        tick();
    endtask

    task automatic test_fairness;
        for (int r = 0; r < 4; r++) begin
            drive_req(0, 1'b1, 1'b0, 8'h20, 1'b0, 16'h0010 + 16'(r), 8'h10 + 8'(r));
            drive_req(1, 1'b0, 1'b1, 8'h30, 1'b1, 16'h2000 + 16'(r), 8'h00);
            push_grant(1'b1, 8'h20, 1'b0, 16'h0010 + 16'(r), 8'h10 + 8'(r));
            push_grant(1'b0, 8'h30, 1'b1, 16'h2000 + 16'(r), 8'h00);
            push_done(2'b01, 2'b00, 1'b0, 8'h00);
            push_done(2'b10, 2'b00, 1'b1, 8'hB0 + 8'(r));
            tick();
            release_req();
            serve(8'hEE);
            checks++;
            if (req_busy !== 2'b11) begin
                errors++;
                $display("FAIL fair_round%0d_busy: busy=%b required 11", r, req_busy);
            end
            serve(8'hB0 + 8'(r));
            tick();
        end
        // Serve requester 0 alone so rr_ptr moves to 1; then requester 1 wins a tie.
        drive_req(0, 1'b1, 1'b0, 8'h21, 1'b0, 16'h0077, 8'h99);
        push_grant(1'b1, 8'h21, 1'b0, 16'h0077, 8'h99);
        push_done(2'b01, 2'b00, 1'b0, 8'h00);
        tick();
        release_req();
        serve(8'h00);
        tick();
        drive_req(0, 1'b1, 1'b0, 8'h22, 1'b1, 16'h0100, 8'h01);
        drive_req(1, 1'b1, 1'b0, 8'h32, 1'b0, 16'h0200, 8'h02);
        push_grant(1'b1, 8'h32, 1'b0, 16'h0200, 8'h02);
        push_grant(1'b1, 8'h22, 1'b1, 16'h0100, 8'h01);
        push_done(2'b10, 2'b00, 1'b0, 8'h00);
        push_done(2'b01, 2'b00, 1'b0, 8'h00);
        tick();
        release_req();
        serve(8'h00);
        serve(8'h00);
        tick();
    endtask

    task automatic test_collisions;
        drive_req(0, 1'b1, 1'b1, 8'h40, 1'b0, 16'h0033, 8'h66);
        push_grant(1'b1, 8'h40, 1'b0, 16'h0033, 8'h66);
        push_done(2'b01, 2'b00, 1'b0, 8'h00);
        tick();                                   // cycle 1: grant cycle, busy
        release_req();
        drive_req(0, 1'b0, 1'b1, 8'h41, 1'b1, 16'h4444, 8'h00);
        tick();                                   // cycle 2
        release_req();
        checks++;
        if (i2c_wrreg_req !== 1'b1 || i2c_rdreg_req !== 1'b0) begin
            errors++;
            $display("FAIL coll_write_only: wrreg=%b rdreg=%b required 1 0", i2c_wrreg_req, i2c_rdreg_req);
        end
        serve(8'h00);
        repeat (6) tick();
        checks++;
        if (req_busy !== 2'b00) begin
            errors++;
            $display("FAIL coll_busy_clear: busy=%b required 00", req_busy);
        end
    endtask

`ifdef I2C_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int n = 0;
        drive_req(0, 1'b0, 1'b1, 8'h60, 1'b0, 16'h0005, 8'h00);
        push_grant(1'b0, 8'h60, 1'b0, 16'h0005, 8'h00);
        push_done(2'b01, 2'b01, 1'b1, 8'h00);
        tick();
        release_req();
        while (!i2c_rdreg_req && n < 50) begin tick(); n++; end
        tick();                                   // first WAIT cycle
        n = 0;
        while (!req_done[0] && n < 200) begin tick(); n++; end
        checks++;
        if (n !== 100 || req_err !== 2'b01 || req_rddata !== 8'h00) begin
            errors++;
            $display("FAIL timeout: wait_cycles=%0d err=%b rddata=%h required 100 01 00", n, req_err, req_rddata);
        end
        tick();
    endtask
`else
    task automatic test_wait_blocks;
        int n = 0;
        int seen = 0;
        drive_req(0, 1'b0, 1'b1, 8'h60, 1'b0, 16'h0005, 8'h00);
        push_grant(1'b0, 8'h60, 1'b0, 16'h0005, 8'h00);
        push_done(2'b01, 2'b00, 1'b1, 8'h5D);
        tick();
        release_req();
        while (!i2c_rdreg_req && n < 50) begin tick(); n++; end
        repeat (150) begin
            tick();
            if (req_done !== 2'b00) seen++;
        end
        checks++;
        if (seen !== 0 || req_busy !== 2'b01) begin
            errors++;
            $display("FAIL wait_blocks: done_cycles=%0d busy=%b required 0 01", seen, req_busy);
        end
        i2c_rddata  = 8'h5D;
        i2c_rw_done = 1'b1;
        tick();
        i2c_rw_done = 1'b0;
        checks++;
        if (req_done !== 2'b01 || req_err !== 2'b00 || req_rddata !== 8'h5D) begin
            errors++;
            $display("FAIL wait_release: done=%b err=%b rddata=%h required 01 00 5d", req_done, req_err, req_rddata);
        end
        tick();
    endtask
`endif

    task automatic test_reset_midflight;
        int n = 0;
        int seen = 0;
        drive_req(0, 1'b1, 1'b0, 8'h70, 1'b1, 16'hABCD, 8'hEF);
        push_grant(1'b1, 8'h70, 1'b1, 16'hABCD, 8'hEF);
        tick();
        release_req();
        while (!i2c_wrreg_req && n < 50) begin tick(); n++; end
        tick();
        tick();                                   // in WAIT
        reset = 1'b1;
        #1;
        checks++;
        if ({req_busy, req_done, req_err, req_rddata, id, addr_mode, addr,
             i2c_wrreg_req, i2c_rdreg_req, i2c_wrdata} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: busy=%b rddata=%h id=%h a=%h d=%h required all 0",
                     req_busy, req_rddata, id, addr, i2c_wrdata);
        end
        repeat (2) tick();
        reset = 1'b0;
        repeat (6) begin
            tick();
            if (req_done !== 2'b00 || req_busy !== 2'b00) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_no_stray: bad_cycles=%0d required 0", seen);
        end
        drive_req(1, 1'b0, 1'b1, 8'h71, 1'b0, 16'h0009, 8'h00);
        push_grant(1'b0, 8'h71, 1'b0, 16'h0009, 8'h00);
        push_done(2'b10, 2'b00, 1'b1, 8'h9E);
        tick();
        release_req();
        serve(8'h9E);
        checks++;
        if (req_done !== 2'b10 || req_rddata !== 8'h9E) begin
            errors++;
            $display("FAIL reset_then_read: done=%b rddata=%h required 10 9e", req_done, req_rddata);
        end
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_return();
        test_fairness();
        test_collisions();
`ifdef I2C_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_wait_blocks();
`endif
        test_reset_midflight();
        checks++;
        if (grant_q.size() != 0) begin
            errors++;
            $display("FAIL grants_outstanding: %0d expected grants never seen, required 0", grant_q.size());
        end
        checks++;
        if (done_q.size() != 0) begin
            errors++;
            $display("FAIL dones_outstanding: %0d expected completions never seen, required 0", done_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
